sorted_insert_writer: RTL and testbench
=======================================

// Module: sorted_insert_writer
// PURPOSE
// - Writer side of the sorted 32x8 lookup RAM that binary_search-style readers consume.
// - Accepts one byte per start handshake and inserts it in ascending order.
// - Shifts larger entries up one address, so the RAM always holds a sorted prefix mem[0..count-1].
// - Drives the single-port synchronous RAM port (address/data/wren in, q out). q reflects mem[address sampled at previous posedge].
// PARAMETERS
// DATA_W  8   entry width
// ADDR_W  5   RAM address width; DEPTH = 2**ADDR_W = 32 entries
// PORTS
// clk       in   1         clock, all logic on posedge
// reset     in   1         synchronous, active-high
// start     in   1         level request; insert D when high in IDLE
// D         in   DATA_W    value to insert, sampled in IDLE when start=1
// address   out  ADDR_W    RAM address
// data      out  DATA_W    RAM write data
// wren      out  1         RAM write enable
// q         in   DATA_W    RAM read data (1-cycle latency)
// count     out  ADDR_W+1  number of valid entries, 0..DEPTH
// full      out  1         count==DEPTH (combinational from count)
// done      out  1         insert complete; high in DONE
// full_err  out  1         start seen while full; high in ERR
// BEHAVIOUR
// - Reset: ps=IDLE, count=0, done=0, full_err=0, wren=0, address=0, data=0.
//   - RAM contents are not cleared; they become logically empty.
// - wren is a state decode gated by !reset, so no write occurs on a reset edge, including mid-insert.
// - Internal regs: in (DATA_W), j (ADDR_W+1, index being examined), pos (ADDR_W), qreg (DATA_W).
// - States and transitions:
//   IDLE:  start & full  -> ERR.
//          start & !full -> in<=D, j<=count-1; count==0 -> INS with pos=0, else -> RD.
//   RD:    address=j[ADDR_W-1:0], wren=0 -> CMP.
//   CMP:   q valid = mem[j].
//          q>in  -> qreg<=q -> SHIFT.
//          q<=in -> pos<=j+1 -> INS. Equal keeps existing entry below: stable, duplicates allowed.
//   SHIFT: address=j+1, data=qreg, wren=1.
//          j==0 -> pos<=0 -> INS; else j<=j-1 -> RD.
//   INS:   address=pos, data=in, wren=1, count<=count+1 -> DONE.
//   DONE:  done=1; start low -> IDLE, else hold. No re-insert while start is held.
//   ERR:   full_err=1, wren=0, count unchanged; start low -> IDLE.
// - Latency: with start first sampled at edge 0, DONE is entered at edge 2 + 3k + 2s.
//   - k = entries shifted.
//   - s = 1 if a compare stopped the scan, 0 if the scan reached index 0 (or count==0).
// - Width rules:
//   - j holds count-1 with count>=1 only; no underflow path.
//   - j+1 <= DEPTH-1 because full blocks insert.
//   - count saturates by construction at DEPTH.
// - Comparison is unsigned on DATA_W bits.
// - D changes after IDLE are ignored (latched in `in`).
// TESTING
// - Reset, start with D=40 on empty:
//   -> one write addr0=40 at edge 2; done high after edge 2; count=1.
// - Insert 20,60,40,10 (start low between), then 30:
//   -> writes mem[4]=60, mem[3]=40, mem[2]=30; DONE at edge 10.
//   -> RAM 10,20,30,40,60; count=5.
// - Insert 20 into {10,20,40}:
//   -> 40 shifted to addr3, new 20 written addr2, old 20 untouched; count=4.
// - Fill to 32, then start with D=5:
//   -> ERR, full_err=1, wren never high, count=32; start low -> IDLE.
// - count=31 all >=1, insert 0:
//   -> 31 shifts then write addr0=0; DONE at edge 95; count=32; full=1.
// - Assert reset during a SHIFT cycle:
//   -> wren low that edge, next cycle IDLE, count=0, done=0, full_err=0.

Source files
------------

// File: rtl/sorted_insert_writer.sv
// Insertion writer for a sorted 32x8 single-port RAM: each start inserts D in
// ascending order, shifting larger entries up one address.
module sorted_insert_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] D,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              full_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, RD, CMP, SHIFT, INS, DONE, ERR} state_t;

  state_t              ps_q, ns_d;
  logic [DATA_W-1:0]   in_q, in_d;
  logic [ADDR_W:0]     j_q, j_d;
  logic [ADDR_W-1:0]   pos_q, pos_d;
  logic [DATA_W-1:0]   qreg_q, qreg_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   jPlus1;

  // j never exceeds DEPTH-2 while shifting, so the low bits are enough for j+1
  assign jPlus1 = j_q[ADDR_W-1:0] + ADDR_W'(1);
  assign full   = (count_q == (ADDR_W+1)'(DEPTH));
  assign count  = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q    <= IDLE;
      in_q    <= '0;
      j_q     <= '0;
      pos_q   <= '0;
      qreg_q  <= '0;
      count_q <= '0;
    end else begin
      ps_q    <= ns_d;
      in_q    <= in_d;
      j_q     <= j_d;
      pos_q   <= pos_d;
      qreg_q  <= qreg_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    ns_d    = ps_q;
    in_d    = in_q;
    j_d     = j_q;
    pos_d   = pos_q;
    qreg_d  = qreg_q;
    count_d = count_q;
    case (ps_q)
      IDLE: begin
        if (start) begin
          if (full) begin
            ns_d = ERR;
          end else begin
            in_d = D;
            j_d  = count_q - (ADDR_W+1)'(1);
            if (count_q == '0) begin
              pos_d = '0;
              ns_d  = INS;
            end else begin
              ns_d = RD;
            end
          end
        end
      end
      RD: ns_d = CMP;
      // Equal values stop the scan so the new entry lands above existing ones
      CMP: begin
        if (q > in_q) begin
          qreg_d = q;
          ns_d   = SHIFT;
        end else begin
          pos_d = jPlus1;
          ns_d  = INS;
        end
      end
      SHIFT: begin
        if (j_q == '0) begin
          pos_d = '0;
          ns_d  = INS;
        end else begin
          j_d  = j_q - (ADDR_W+1)'(1);
          ns_d = RD;
        end
      end
      INS: begin
        count_d = count_q + (ADDR_W+1)'(1);
        ns_d    = DONE;
      end
      DONE: if (!start) ns_d = IDLE;
      ERR:  if (!start) ns_d = IDLE;
      default: ns_d = IDLE;
    endcase
  end

  // Write enable is masked by reset so an aborted insert never corrupts the RAM
  always_comb begin
    address  = '0;
    data     = '0;
    wren     = 1'b0;
    done     = 1'b0;
    full_err = 1'b0;
    case (ps_q)
      RD: address = j_q[ADDR_W-1:0];
      SHIFT: begin
        address = jPlus1;
        data    = qreg_q;
        wren    = !reset;
      end
      INS: begin
        address = pos_q;
        data    = in_q;
        wren    = !reset;
      end
      DONE: done = 1'b1;
      ERR:  full_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sorted_insert_writer.sv
// Directed bench for sorted_insert_writer with a behavioural synchronous RAM,
// checking latency, counts, written addresses and final RAM contents.
module tb_sorted_insert_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] D = '0;
  logic [4:0] address;
  logic [7:0] data;
  logic       wren;
  logic [7:0] q = '0;
  logic [5:0] count;
  logic       full;
  logic       done;
  logic       fullErr;

  logic       clearMem = 1'b0;
  logic [7:0] mem [0:31];
  logic [4:0] wrAddrLog [0:4095];
  int         wrN = 0;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit         rst;
    logic [7:0] d;
    int         edges;
    int         cnt;
    logic [31:0] mask;
  } vec_t;

  vec_t vecs [10];

  sorted_insert_writer #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .D(D),
    .address(address), .data(data), .wren(wren), .q(q),
    .count(count), .full(full), .done(done), .full_err(fullErr)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency; every write address is logged
  always @(posedge clk) begin
    q <= mem[address];
    if (clearMem) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'hEE;
    end else if (wren) begin
      mem[address] <= data;
      wrAddrLog[wrN[11:0]] <= address;
      wrN <= wrN + 1;
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic doReset(input bit clr);
    reset = 1'b1;
    start = 1'b0;
    clearMem = clr;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clearMem = 1'b0;
  endtask

  // Raises start just after an edge (edge 0) and counts edges until done is seen
  task automatic applyStimulus(input logic [7:0] d, output int edges, output logic [31:0] mask);
    int base;
    base = wrN;
    D = d;
    start = 1'b1;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      D = ~d;
    end while (!done && edges < 200);
    mask = '0;
    for (int k = base; k < wrN; k++) mask |= 32'd1 << wrAddrLog[k[11:0]];
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    logic [31:0] mask;
    logic [7:0] ram1 [5];
    logic [7:0] ram2 [4];
    int base;

    vecs[0] = '{1'b1, 8'd40, 2,  1, 32'b1};
    vecs[1] = '{1'b1, 8'd20, 2,  1, 32'b1};
    vecs[2] = '{1'b0, 8'd60, 4,  2, 32'b10};
    vecs[3] = '{1'b0, 8'd40, 7,  3, 32'b110};
    vecs[4] = '{1'b0, 8'd10, 11, 4, 32'b1111};
    vecs[5] = '{1'b0, 8'd30, 10, 5, 32'b11100};
    vecs[6] = '{1'b1, 8'd10, 2,  1, 32'b1};
    vecs[7] = '{1'b0, 8'd20, 4,  2, 32'b10};
    vecs[8] = '{1'b0, 8'd40, 4,  3, 32'b100};
    vecs[9] = '{1'b0, 8'd20, 7,  4, 32'b1100};
    ram1 = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd60};
    ram2 = '{8'd10, 8'd20, 8'd20, 8'd40};

    doReset(1'b1);
    checkOutput("rstCount", count, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstFullErr", fullErr, 0);
    checkOutput("rstWren", wren, 0);
    checkOutput("rstAddr", address, 0);
    checkOutput("rstFull", full, 0);

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].rst) doReset(1'b1);
      applyStimulus(vecs[v].d, edges, mask);
      checkOutput($sformatf("vec%0dEdges", v), edges, vecs[v].edges);
      checkOutput($sformatf("vec%0dCount", v), count, vecs[v].cnt);
      checkOutput($sformatf("vec%0dMask", v), mask, vecs[v].mask);
      checkOutput($sformatf("vec%0dDoneClr", v), done, 0);
      if (v == 5) for (int i = 0; i < 5; i++)
        checkOutput($sformatf("ram1_%0d", i), mem[i], ram1[i]);
      if (v == 9) for (int i = 0; i < 4; i++)
        checkOutput($sformatf("ram2_%0d", i), mem[i], ram2[i]);
    end

    // Reset asserted while a shift write is pending
    doReset(1'b1);
    applyStimulus(8'd10, edges, mask);
    applyStimulus(8'd20, edges, mask);
    applyStimulus(8'd30, edges, mask);
    D = 8'd5;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("shiftWren", wren, 1);
    checkOutput("shiftAddr", address, 3);
    checkOutput("shiftData", data, 30);
    reset = 1'b1;
    #1;
    checkOutput("rstShiftWren", wren, 0);
    base = wrN;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    checkOutput("rstShiftNoWrite", wrN - base, 0);
    checkOutput("rstShiftMem3", mem[3], 8'hEE);
    checkOutput("rstShiftCount", count, 0);
    checkOutput("rstShiftDone", done, 0);
    checkOutput("rstShiftFullErr", fullErr, 0);
    applyStimulus(8'd7, edges, mask);
    checkOutput("recoverEdges", edges, 2);
    checkOutput("recoverMem0", mem[0], 7);

    // Fill with 1..31, then insert 0 to force a full-length shift
    doReset(1'b1);
    for (int i = 1; i <= 31; i++) begin
      applyStimulus(8'(i), edges, mask);
      checkOutput($sformatf("fill%0dEdges", i), edges, (i == 1) ? 2 : 4);
    end
    checkOutput("fill31Count", count, 31);
    checkOutput("fill31Full", full, 0);
    applyStimulus(8'd0, edges, mask);
    checkOutput("zeroEdges", edges, 95);
    checkOutput("zeroCount", count, 32);
    checkOutput("zeroFull", full, 1);
    for (int i = 0; i < 32; i++) checkOutput($sformatf("fullRam%0d", i), mem[i], i);

    base = wrN;
    D = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("errFlag", fullErr, 1);
    checkOutput("errDone", done, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("errHold", fullErr, 1);
    checkOutput("errCount", count, 32);
    checkOutput("errNoWrite", wrN - base, 0);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("errExit", fullErr, 0);
    checkOutput("errCountAfter", count, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
